dtree_node_mem: RTL and testbench

//  Per-channel decision-tree node store feeding the tree control FSM. A serial

---
 rtl/dtree_node_mem.sv | 137 +++++++++++++
 tb/tb_dtree_node_mem.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_node_mem.sv
// Decision-tree node store: serial configuration load, combinational node reads.
// Optional macro NODE_MEM_READBACK_EN adds a delayed serial readback on cfg_dout.
module dtree_node_mem #(
    parameter int FEATURES      = 3,
    parameter int COEFF_WIDTH   = 4,
    parameter int BIAS_WIDTH    = 10,
    parameter int MAX_CLUSTERS  = 5,
    parameter int CHANNEL_COUNT = 1,
    localparam int NODES_PER_CH = MAX_CLUSTERS - 1,
    localparam int NODE_SIZE    = 2 + FEATURES + (FEATURES - 1) * COEFF_WIDTH + BIAS_WIDTH + 1,
    localparam int TOTAL        = CHANNEL_COUNT * NODES_PER_CH,
    localparam int CH_W         = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1,
    localparam int NI_W         = $clog2(MAX_CLUSTERS),
    localparam int AW           = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic                 cfg_valid,
    input  logic                 cfg_bit,
    output logic                 cfg_dout,
    output logic                 cfg_error,
    output logic                 mem_ready,
    input  logic [CH_W-1:0]      ch_index,
    input  logic [NI_W-1:0]      node_index,
    input  logic                 read_mem,
    output logic [NODE_SIZE-1:0] node_data
);

    localparam int BC_W = $clog2(NODE_SIZE);
    localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(NODE_SIZE - 1);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(TOTAL - 1);
`ifdef NODE_MEM_READBACK_EN
    localparam int SR_W = NODE_SIZE;
`else
    localparam int SR_W = NODE_SIZE - 1;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BC_W-1:0]     bit_cnt;
    logic [AW-1:0]       word_addr;
    logic [SR_W-1:0]     shift_reg;
    logic [NODE_SIZE-1:0] mem [TOTAL];
    logic [15:0]         rd_cnt;
    logic                load_bit;
    logic                word_done;
    logic                err_set;
    logic [AW-1:0]       rd_addr;

    // cfg_start overrides everything, so a bit arriving with it is dropped.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latches are inferred.
        state_nxt = state;
        load_bit  = 1'b0;
        word_done = 1'b0;
        err_set   = 1'b0;
        if (cfg_start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:  err_set = cfg_valid;
                LOAD: begin
                    if (cfg_valid) begin
                        load_bit = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            word_done = 1'b1;
                            if (word_addr == LAST_ADDR) state_nxt = READY;
                        end
                    end
                end
                READY: err_set = cfg_valid;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset || cfg_start) begin
            bit_cnt   <= '0;
            word_addr <= '0;
            shift_reg <= '0;
            cfg_error <= 1'b0;
        end else begin
            if (err_set) cfg_error <= 1'b1;
            if (load_bit) begin
                shift_reg <= {shift_reg[SR_W-2:0], cfg_bit};
                bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
                if (word_done) word_addr <= word_addr + 1'b1;
            end
        end
    end

    // NOTE: the node array is deliberately left out of reset; committed words survive it.
    always_ff @(posedge clk) begin
        if (word_done) mem[word_addr] <= {shift_reg[NODE_SIZE-2:0], cfg_bit};
    end

    always_ff @(posedge clk) begin
        if (reset)                        rd_cnt <= '0;
        else if (read_mem && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
    end

    assign mem_ready = (state == READY);

    always_comb begin
        node_data = '0;
        rd_addr   = AW'(32'(ch_index) * 32'(NODES_PER_CH) + 32'(node_index));
        if (32'(ch_index) < 32'(CHANNEL_COUNT) && 32'(node_index) < 32'(NODES_PER_CH))
            node_data = mem[rd_addr];
    end

`ifdef NODE_MEM_READBACK_EN
    logic dout_q;

    always_ff @(posedge clk) begin
        if (reset || cfg_start) dout_q <= 1'b0;
        else if (load_bit)      dout_q <= shift_reg[NODE_SIZE-1];
    end

    assign cfg_dout = dout_q & (state == LOAD);
`else
    assign cfg_dout = 1'b0;
`endif

endmodule

// File: tb/tb_dtree_node_mem.sv
// Scoreboard bench for dtree_node_mem: one default instance and one with two channels.
module tb_dtree_node_mem;

    localparam int NS = 24;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0, read_mem = 1'b0;
    logic        cfg_dout, cfg_error, mem_ready;
    logic [0:0]  ch_index = '0;
    logic [2:0]  node_index = '0;
    logic [23:0] node_data;

    logic        cfg_start2 = 1'b0, cfg_valid2 = 1'b0, cfg_bit2 = 1'b0, read_mem2 = 1'b0;
    logic        cfg_dout2, cfg_error2, mem_ready2;
    logic [0:0]  ch_index2 = '0;
    logic [2:0]  node_index2 = '0;
    logic [23:0] node_data2;

    always #5 clk = ~clk;

    dtree_node_mem dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_bit(cfg_bit), .cfg_dout(cfg_dout), .cfg_error(cfg_error),
        .mem_ready(mem_ready), .ch_index(ch_index), .node_index(node_index),
        .read_mem(read_mem), .node_data(node_data)
    );

    dtree_node_mem #(.CHANNEL_COUNT(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start2), .cfg_valid(cfg_valid2),
        .cfg_bit(cfg_bit2), .cfg_dout(cfg_dout2), .cfg_error(cfg_error2),
        .mem_ready(mem_ready2), .ch_index(ch_index2), .node_index(node_index2),
        .read_mem(read_mem2), .node_data(node_data2)
    );

    typedef struct {
        string       name;
        logic [23:0] data;
        logic        rdy;
        logic        err;
        logic        dout;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    exp_t        e_mon;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] m1[4];
    bit          k1[4];
    logic [23:0] m2[8];
    bit          k2[8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every read strobe presents a response that must match the next queued entry.
    always @(negedge clk) begin
        if (read_mem) begin
            if (q1.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL dut1_strobe: got strobe expected none queued");
            end else begin
                e_mon = q1.pop_front();
                check({e_mon.name, "/data"},  {8'h0, node_data}, {8'h0, e_mon.data});
                check({e_mon.name, "/ready"}, {31'h0, mem_ready}, {31'h0, e_mon.rdy});
                check({e_mon.name, "/error"}, {31'h0, cfg_error}, {31'h0, e_mon.err});
                check({e_mon.name, "/dout"},  {31'h0, cfg_dout},  {31'h0, e_mon.dout});
            end
        end
        if (read_mem2) begin
            if (q2.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL dut2_strobe: got strobe expected none queued");
            end else begin
                e_mon = q2.pop_front();
                check({e_mon.name, "/data"},  {8'h0, node_data2}, {8'h0, e_mon.data});
                check({e_mon.name, "/ready"}, {31'h0, mem_ready2}, {31'h0, e_mon.rdy});
                check({e_mon.name, "/error"}, {31'h0, cfg_error2}, {31'h0, e_mon.err});
                check({e_mon.name, "/dout"},  {31'h0, cfg_dout2},  {31'h0, e_mon.dout});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [23:0] exp_node(input int which, input int ch, input int node);
        if (which == 1) return (ch < 1 && node < 4) ? m1[node] : 24'h0;
        return (ch < 2 && node < 4) ? m2[ch*4+node] : 24'h0;
    endfunction

    function automatic bit known(input int which, input int node);
        return (which == 1) ? k1[node] : k2[node];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        read_mem   = 1'b0;
        read_mem2  = 1'b0;
        cfg_start  = 1'b0;
        cfg_start2 = 1'b0;
    endtask

    task automatic strobe(input int which, input int ch, input int node, input logic rdy,
                          input logic err, input logic dout, input string nm);
        exp_t e;
        e.name = nm;
        e.data = exp_node(which, ch, node);
        e.rdy  = rdy;
        e.err  = err;
        e.dout = dout;
        if (which == 1) begin
            ch_index = 1'(ch); node_index = 3'(node); read_mem = 1'b1; q1.push_back(e);
        end else begin
            ch_index2 = 1'(ch); node_index2 = 3'(node); read_mem2 = 1'b1; q2.push_back(e);
        end
    endtask

    task automatic rd(input int which, input int ch, input int node, input logic rdy,
                      input logic err, input string nm);
        strobe(which, ch, node, rdy, err, 1'b0, nm);
        tick();
    endtask

    // Streams nbits MSB-first; word w is base (or base|w). Reads a known node every bit.
    task automatic load_image(input int which, input logic [23:0] base, input bit add_idx,
                              input int nbits);
        bit hist[$];
        for (int i = 0; i < nbits; i++) begin
            int          w;
            int          b;
            int          node;
            logic [23:0] v;
            logic        dexp;
            w    = i / NS;
            b    = NS - 1 - (i % NS);
            v    = base | (add_idx ? 24'(w) : 24'h0);
            dexp = 1'b0;
`ifdef NODE_MEM_READBACK_EN
            if (i >= 25) dexp = hist[i-25];
`endif
            node = i % 5;
            if (node < 4 && !known(which, node)) node = 4;
            if (which == 1) begin cfg_valid = 1'b1; cfg_bit = v[b]; end
            else begin cfg_valid2 = 1'b1; cfg_bit2 = v[b]; end
            strobe(which, 0, node, 1'b0, 1'b0, dexp, $sformatf("dut%0d_load_bit%0d", which, i));
            hist.push_back(v[b]);
            tick();
            if (i % NS == NS - 1) begin
                if (which == 1) begin m1[w] = v; k1[w] = 1'b1; end
                else begin m2[w] = v; k2[w] = 1'b1; end
            end
        end
        cfg_valid  = 1'b0;
        cfg_valid2 = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        rd(1, 0, 4, 1'b0, 1'b0, "reset_state");
        rd(2, 0, 4, 1'b0, 1'b0, "reset_state2");

        // Data in IDLE is an error.
        cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_valid = 1'b0;
        rd(1, 0, 4, 1'b0, 1'b1, "idle_valid_err");

        // Test 1, with a bit presented alongside cfg_start that must be dropped.
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
        tick();
        cfg_valid = 1'b0;
        rd(1, 0, 4, 1'b0, 1'b0, "start_clears_err");
        load_image(1, 24'hA00000, 1'b1, 96);
        rd(1, 0, 2, 1'b1, 1'b0, "t1_node2");
        for (int n = 0; n < 4; n++) rd(1, 0, n, 1'b1, 1'b0, $sformatf("t1_node%0d", n));
        rd(1, 1, 0, 1'b1, 1'b0, "t1_ch_oor");
        rd(1, 0, 7, 1'b1, 1'b0, "t1_node7_oor");

        // Test 3: stray bit in READY.
        cfg_valid = 1'b1; cfg_bit = 1'b0;
        tick();
        cfg_valid = 1'b0;
        rd(1, 0, 2, 1'b1, 1'b1, "t3_err_set");
        rd(1, 0, 2, 1'b1, 1'b1, "t3_err_sticky");
        cfg_start = 1'b1;
        tick();
        rd(1, 0, 2, 1'b0, 1'b0, "t3_start_clears");

        // Test 2: partial image abandoned, then a full image.
        load_image(1, 24'h123400, 1'b1, 48);
        cfg_start = 1'b1;
        tick();
        rd(1, 0, 1, 1'b0, 1'b0, "t2_after_restart");
        load_image(1, 24'h5A5A5A, 1'b0, 96);
        for (int n = 0; n < 4; n++) rd(1, 0, n, 1'b1, 1'b0, $sformatf("t2_node%0d", n));

        // Test 4: two channels.
        cfg_start2 = 1'b1;
        tick();
        load_image(2, 24'hB00000, 1'b1, 192);
        rd(2, 1, 3, 1'b1, 1'b0, "t4_ch1_node3");
        rd(2, 0, 2, 1'b1, 1'b0, "t4_ch0_node2");
        rd(2, 1, 0, 1'b1, 1'b0, "t4_ch1_node0");
        rd(2, 1, 4, 1'b1, 1'b0, "t4_node4_oor");
        rd(2, 0, 7, 1'b1, 1'b0, "t4_node7_oor");

        // Test 5: reset mid-load keeps committed words; next load replaces them.
        cfg_start = 1'b1;
        tick();
        load_image(1, 24'hC00000, 1'b1, 30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(1, 0, 0, 1'b0, 1'b0, "t5_word0_kept");
        rd(1, 0, 1, 1'b0, 1'b0, "t5_word1_old");
        cfg_start = 1'b1;
        tick();
        load_image(1, 24'h0F0F00, 1'b1, 96);
        rd(1, 0, 0, 1'b1, 1'b0, "t5_word0_new");
        rd(1, 0, 3, 1'b1, 1'b0, "t5_word3_new");

        repeat (2) tick();
        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
